// File: rtl/baud_pkg.sv
// Shared definitions for the UART baud generation path: divisor layout,
// default widths and the reset-divisor calculation.
package baud_pkg;

  localparam int DIV_INT_W_DEF  = 16;
  localparam int DIV_FRAC_W_DEF = 4;

  // Anything below two clocks per oversample period cannot form a tick.
  localparam int MIN_DIV_INT = 2;

  typedef struct packed {
    logic [DIV_INT_W_DEF-1:0]  div_int;
    logic [DIV_FRAC_W_DEF-1:0] div_frac;
  } baud_div_t;

  // Fixed-point divisor (int.frac) that yields baud * oversample ticks per second.
  function automatic longint unsigned calc_default_div(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input longint unsigned oversample,
    input int              frac_w
  );
    return (clk_freq << frac_w) / (baud * oversample);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Generic N-to-1 pulse divider: emits one registered pulse for every N input
// pulses. clr realigns the count without producing an output pulse.
module tick_divider #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick_in,
  output logic tick_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and output pulse; count only advances on an input pulse.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_in) begin
      if (cnt_q == CW'(N - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_out = tick_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator. A period counter produces os_tick with an
// average period of div_int + div_frac/2^DIV_FRAC_W clocks; tick_divider
// folds OVERSAMPLE os_ticks into one baud_tick. The divisor can be rewritten
// at run time and is swapped in on a period boundary.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int          DIV_INT_W    = DIV_INT_W_DEF,
  parameter int          DIV_FRAC_W   = DIV_FRAC_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            restart,
  input  logic                            div_wr,
  input  logic [DIV_INT_W+DIV_FRAC_W-1:0] div_in,
  output logic [DIV_INT_W+DIV_FRAC_W-1:0] div_active,
  output logic                            div_busy,
  output logic                            cfg_err,
  output logic                            os_tick,
  output logic                            baud_tick
);

  localparam int DIV_W = DIV_INT_W + DIV_FRAC_W;
  localparam int CW    = DIV_INT_W + 1;
  localparam int AW    = DIV_FRAC_W + 1;

  localparam logic [DIV_W-1:0] DEFAULT_DIV =
    DIV_W'(calc_default_div(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE, DIV_FRAC_W));

  logic [DIV_INT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_FRAC_W-1:0] acc_q, acc_d;
  logic                  carry_q, carry_d;
  logic [DIV_W-1:0]      div_active_q, div_active_d;
  logic [DIV_W-1:0]      pend_q, pend_d;
  logic                  busy_q, busy_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  os_tick_q, os_tick_d;

  logic [DIV_INT_W-1:0]  act_int;
  logic [DIV_FRAC_W-1:0] act_frac;
  logic [DIV_INT_W-1:0]  wr_int;
  logic                  wr_ok;
  logic [CW-1:0]         period_m1;
  logic                  at_end;
  logic [AW-1:0]         frac_sum;
  logic                  wrap;

  // Divisor field decode, write validation and end-of-period detection.
  always_comb begin
    act_int   = div_active_q[DIV_W-1 -: DIV_INT_W];
    act_frac  = div_active_q[DIV_FRAC_W-1:0];
    wr_int    = div_in[DIV_W-1 -: DIV_INT_W];
    wr_ok     = div_wr && (wr_int >= DIV_INT_W'(MIN_DIV_INT));
    period_m1 = {1'b0, act_int} + CW'(carry_q) - CW'(1);
    // A divisor applied while paused can be shorter than the held phase;
    // >= makes the counter wrap on the next enabled edge instead of running
    // off to overflow.
    at_end    = ({1'b0, cnt_q} >= period_m1);
    frac_sum  = {1'b0, acc_q} + {1'b0, act_frac};
    wrap      = en && !restart && at_end;
  end

  // Next-state logic for the period counter, accumulator and divisor update.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    div_active_d = div_active_q;
    pend_d       = pend_q;
    busy_d       = busy_q;
    cfg_err_d    = div_wr && !wr_ok;
    os_tick_d    = 1'b0;

    if (restart) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      if (busy_q) begin
        div_active_d = pend_q;
      end
      if (wr_ok) begin
        pend_d = div_in;
        busy_d = 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end else if (en) begin
      if (at_end) begin
        cnt_d              = '0;
        {carry_d, acc_d}   = frac_sum;
        os_tick_d          = 1'b1;
        if (wr_ok) begin
          div_active_d = div_in;
          busy_d       = 1'b0;
        end else if (busy_q) begin
          div_active_d = pend_q;
          busy_d       = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + DIV_INT_W'(1);
        if (wr_ok) begin
          pend_d = div_in;
          busy_d = 1'b1;
        end
      end
    end else begin
      // Paused: no wrap will come, so a pending divisor goes in right away.
      // A fresh write replaces whatever is pending and lands one edge later.
      if (wr_ok) begin
        pend_d = div_in;
        busy_d = 1'b1;
      end else if (busy_q) begin
        div_active_d = pend_q;
        busy_d       = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      div_active_q <= DEFAULT_DIV;
      pend_q       <= DEFAULT_DIV;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      os_tick_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
      div_active_q <= div_active_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
      os_tick_q    <= os_tick_d;
    end
  end

  tick_divider #(
    .N (OVERSAMPLE)
  ) u_baud_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (restart),
    .tick_in  (wrap),
    .tick_out (baud_tick)
  );

  assign div_active = div_active_q;
  assign div_busy   = busy_q;
  assign cfg_err    = cfg_err_q;
  assign os_tick    = os_tick_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac with default parameters: directed scenarios with
// literal timing expectations, then randomized traffic, all cross-checked
// every cycle against a cycle-level arithmetic model.
module tb_baud_gen_frac;

  localparam int OS      = 16;
  localparam int FSCALE  = 16;
  localparam int DEF_DIV = 10416;

  logic        clk;
  logic        rst;
  logic        en;
  logic        restart;
  logic        div_wr;
  logic [19:0] div_in;
  logic [19:0] div_active;
  logic        div_busy;
  logic        cfg_err;
  logic        os_tick;
  logic        baud_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  baud_gen_frac dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .restart    (restart),
    .div_wr     (div_wr),
    .div_in     (div_in),
    .div_active (div_active),
    .div_busy   (div_busy),
    .cfg_err    (cfg_err),
    .os_tick    (os_tick),
    .baud_tick  (baud_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: phase = clocks elapsed in the current oversample period,
  // period length = int part plus the carry owed by the fractional sum.
  int m_div, m_pend, m_phase, m_acc, m_carry, m_osn;
  bit m_busy, e_os, e_baud, e_err, m_valid = 1'b0;

  task automatic model_step();
    int len, sum;
    bit ok;
    if (rst) begin
      m_div = DEF_DIV; m_pend = DEF_DIV; m_busy = 0;
      m_phase = 0; m_acc = 0; m_carry = 0; m_osn = 0;
      e_os = 0; e_baud = 0; e_err = 0; m_valid = 1;
      return;
    end
    ok    = div_wr && ((int'(div_in) / FSCALE) >= 2);
    e_err = div_wr && !ok;
    e_os  = 0;
    e_baud = 0;
    if (restart) begin
      m_phase = 0; m_acc = 0; m_carry = 0; m_osn = 0;
      if (m_busy) m_div = m_pend;
      if (ok) begin m_pend = int'(div_in); m_busy = 1; end
      else m_busy = 0;
    end else if (en) begin
      len = m_div / FSCALE + m_carry;
      if (m_phase + 1 >= len) begin
        e_os   = 1;
        e_baud = (m_osn == OS - 1);
        m_osn  = (m_osn + 1) % OS;
        sum     = m_acc + (m_div % FSCALE);
        m_carry = sum / FSCALE;
        m_acc   = sum % FSCALE;
        m_phase = 0;
        if (ok) begin m_div = int'(div_in); m_busy = 0; end
        else if (m_busy) begin m_div = m_pend; m_busy = 0; end
      end else begin
        m_phase++;
        if (ok) begin m_pend = int'(div_in); m_busy = 1; end
      end
    end else begin
      if (ok) begin m_pend = int'(div_in); m_busy = 1; end
      else if (m_busy) begin m_div = m_pend; m_busy = 0; end
    end
  endtask

  always @(posedge clk) model_step();

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("os_tick", int'(os_tick), int'(e_os));
      chk("baud_tick", int'(baud_tick), int'(e_baud));
      chk("cfg_err", int'(cfg_err), int'(e_err));
      chk("div_busy", int'(div_busy), int'(m_busy));
      chk("div_active", int'(div_active), m_div);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_os(input int maxc, output int at);
    at = -1000000;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (os_tick) begin at = cyc; break; end
    end
  endtask

  task automatic wait_baud(input int maxc, output int at);
    at = -1000000;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (baud_tick) begin at = cyc; break; end
    end
  endtask

  // Write a divisor, then restart so it is active with a clean phase.
  // Returns the cycle in which restart was sampled.
  task automatic load_restart(input int val, output int r);
    div_wr = 1'b1; div_in = 20'(val);
    @(negedge clk);
    div_wr = 1'b0; restart = 1'b1; r = cyc;
    @(negedge clk);
    restart = 1'b0;
  endtask

  int exp_frac[5] = '{5, 9, 14, 18, 23};

  initial begin
    int t0, a, a2, b1, b2, b3, r, t, n, nt;
    rst = 1'b1; en = 1'b0; restart = 1'b0; div_wr = 1'b0; div_in = '0;
    repeat (3) @(negedge clk);

    // Reset defaults and first-tick latency.
    rst = 1'b0; en = 1'b1; t0 = cyc;
    chk("rst_div_active", int'(div_active), 10416);
    chk("rst_os_tick", int'(os_tick), 0);
    wait_os(700, a);
    chk("first_os_cycle", a - t0, 651);
    wait_os(700, a2);
    chk("os_spacing_default", a2 - a, 651);
    wait_baud(11000, b1);
    chk("first_baud_cycle", b1 - t0, 10416);

    // Fractional divisor 4 + 8/16.
    load_restart(72, r);
    for (int k = 0; k < 5; k++) begin
      wait_os(10, a);
      chk("frac_os_offset", a - r, exp_frac[k]);
    end
    wait_baud(200, b1);
    wait_baud(100, b2);
    wait_baud(100, b3);
    chk("frac_first_baud", b1 - r, 72);
    chk("frac_baud_spacing", b2 - b1, 72);
    chk("frac_two_baud", b3 - b1, 144);

    // Mid-period update: active 10, write 6 so it lands with cnt=3.
    load_restart(160, r);
    wait_os(20, t);
    repeat (2) @(negedge clk);
    div_wr = 1'b1; div_in = 20'(96);
    @(negedge clk);
    div_wr = 1'b0;
    n = 0;
    while (div_busy && n < 20) begin n++; @(negedge clk); end
    chk("busy_cycles", n, 7);
    chk("old_period_done", int'(os_tick), 1);
    chk("old_period_len", cyc - t, 10);
    t = cyc;
    wait_os(10, a);
    chk("new_period_len", a - t, 6);

    // Illegal divisor.
    div_wr = 1'b1; div_in = 20'(19);
    @(negedge clk);
    div_wr = 1'b0;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    chk("illegal_keeps_div", int'(div_active), 96);
    @(negedge clk);
    chk("cfg_err_single", int'(cfg_err), 0);
    wait_os(20, a);
    wait_os(20, a2);
    chk("illegal_spacing", a2 - a, 6);

    // Pause at cnt=5 for 20 cycles with period 10.
    load_restart(160, r);
    wait_os(20, t);
    repeat (5) @(negedge clk);
    en = 1'b0;
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (os_tick) nt++;
    end
    chk("paused_ticks", nt, 0);
    en = 1'b1; t = cyc;
    wait_os(20, a);
    chk("resume_latency", a - t, 5);

    // Restart mid-period.
    repeat (3) @(negedge clk);
    restart = 1'b1; r = cyc;
    @(negedge clk);
    restart = 1'b0;
    wait_os(30, a);
    chk("restart_latency", a - r, 11);

    // Reset while a write is pending.
    div_wr = 1'b1; div_in = 20'(96);
    @(negedge clk);
    div_wr = 1'b0;
    chk("pending_busy", int'(div_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_div", int'(div_active), 10416);
    chk("rst_mid_busy", int'(div_busy), 0);
    chk("rst_mid_os", int'(os_tick), 0);
    chk("rst_mid_baud", int'(baud_tick), 0);
    rst = 1'b0;
    load_restart(64 + 3, r);

    // Randomized traffic; the compare process does the checking.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(999) < 2);
      en      = ($urandom_range(99) < 85);
      restart = ($urandom_range(99) < 2);
      div_wr  = ($urandom_range(99) < 5);
      div_in  = {16'($urandom_range(9)), 4'($urandom_range(15))};
    end
    rst = 1'b0; en = 1'b1; restart = 1'b0; div_wr = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
